usb_bulk_ep_fifo: RTL

Parametrised bulk endpoint with a FIFO-backed loopback that implements the full USB handshake protocol. OUT data is staged speculatively and committed only on a good packet; IN data is streamed byte-serially and retired only on host ACK, with rewind and retransmit otherwise. It also provides independent data toggles per direction, NAK flow control and STALL. It sits between the packet interface (token, data and handshake decode/encode) and the application, replacing the fixed EP1 loopback.

---
 rtl/usb_bulk_ep_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/usb_bulk_ep_fifo.sv
// usb_bulk_ep_fifo: bulk endpoint FIFO loopback with speculative OUT commit and ACK-retired IN retransmit
module usb_bulk_ep_fifo #(
  parameter int EP_NUM = 1,
  parameter int DEPTH = 64,
  parameter int MAX_PKT = 64,
  parameter int TIMEOUT_CYC = 255,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
  localparam int PW = $clog2(MAX_PKT) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_tok_valid,
  input  logic [3:0]    rx_tok_pid,
  input  logic [3:0]    rx_tok_ep,
  input  logic          rx_data_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_pkt_end,
  input  logic [3:0]    rx_pkt_pid,
  input  logic          rx_crc_err,
  input  logic          rx_hs_valid,
  input  logic [3:0]    rx_hs_pid,
  output logic          tx_hs_valid,
  output logic [3:0]    tx_hs_pid,
  output logic          tx_start,
  output logic [3:0]    tx_pid,
  output logic [PW-1:0] tx_len,
  output logic          tx_byte_valid,
  output logic [7:0]    tx_byte,
  input  logic          tx_byte_ready,
  input  logic          stall_set,
  input  logic          stall_clr,
  output logic          stalled,
  output logic [LW-1:0] fifo_level
);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0] PID_OUT = 4'b0001, PID_IN = 4'b1001, PID_DATA0 = 4'b0011, PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_PKT);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_PKT);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, OUT_DATA, IN_SEND, IN_WAIT} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_commit, wr_spec, rd_commit, rd_spec;
  logic [LW-1:0] level;
  logic [CW-1:0] cnt;
  logic [PW-1:0] sent;
  logic [TW-1:0] timer;
  logic out_tog, in_tog, nak_f, stall_f;
  logic my_tok, wr_en, in_ack;
  assign my_tok = rx_tok_valid && rx_tok_ep == 4'(EP_NUM);
  assign wr_en = state == OUT_DATA && rx_data_valid && !nak_f && !stall_f && cnt < MAX_C;
  assign in_ack = state == IN_WAIT && rx_hs_valid && rx_hs_pid == PID_ACK;
  assign fifo_level = level;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_spec] <= rx_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_commit <= '0;
      wr_spec <= '0;
      rd_commit <= '0;
      rd_spec <= '0;
      level <= '0;
      cnt <= '0;
      sent <= '0;
      timer <= '0;
      out_tog <= 1'b0;
      in_tog <= 1'b0;
      nak_f <= 1'b0;
      stall_f <= 1'b0;
      stalled <= 1'b0;
      tx_hs_valid <= 1'b0;
      tx_hs_pid <= '0;
      tx_start <= 1'b0;
      tx_pid <= '0;
      tx_len <= '0;
      tx_byte_valid <= 1'b0;
      tx_byte <= '0;
    end else begin
      tx_hs_valid <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        OUT_DATA: begin
          if (wr_en) wr_spec <= wr_spec + AW'(1);
          if (rx_data_valid && cnt <= MAX_C) cnt <= cnt + CW'(1);
          if (rx_pkt_end) begin
            state <= IDLE;
            tx_hs_valid <= !rx_crc_err;
            if (!rx_crc_err)
              tx_hs_pid <= (stall_f || (!nak_f && cnt > MAX_C)) ? PID_STALL : nak_f ? PID_NAK : PID_ACK;
            if (!rx_crc_err && !stall_f && !nak_f && cnt > MAX_C) stalled <= 1'b1;
            if (!rx_crc_err && !stall_f && !nak_f && cnt <= MAX_C &&
                rx_pkt_pid == (out_tog ? PID_DATA1 : PID_DATA0)) begin
              wr_commit <= wr_spec;
              level <= level + LW'(cnt);
              out_tog <= ~out_tog;
            end
          end
        end
        IDLE, IN_WAIT: begin
          if (in_ack) begin
            rd_commit <= rd_spec;
            level <= level - LW'(tx_len);
            in_tog <= ~in_tog;
            state <= IDLE;
          end else if (state == IN_WAIT && !rx_tok_valid && timer != T_LAST) begin
            timer <= timer + TW'(1);
          end else begin
            state <= IDLE;
            rd_spec <= rd_commit;
            if (my_tok && rx_tok_pid == PID_OUT) begin
              state <= OUT_DATA;
              wr_spec <= wr_commit;
              cnt <= '0;
              nak_f <= (DEPTH_L - level) < MAX_L;
              stall_f <= stalled;
            end else if (my_tok && rx_tok_pid == PID_IN) begin
              if (stalled || level == '0) begin
                tx_hs_valid <= 1'b1;
                tx_hs_pid <= stalled ? PID_STALL : PID_NAK;
              end else begin
                tx_start <= 1'b1;
                tx_pid <= in_tog ? PID_DATA1 : PID_DATA0;
                tx_len <= level > MAX_L ? PW'(MAX_PKT) : PW'(level);
                sent <= '0;
                state <= IN_SEND;
              end
            end
          end
        end
        default: begin
          if (!tx_byte_valid) begin
            tx_byte_valid <= 1'b1;
            tx_byte <= mem[rd_spec];
          end else if (tx_byte_ready) begin
            rd_spec <= rd_spec + AW'(1);
            sent <= sent + PW'(1);
            if (sent == tx_len - PW'(1)) begin
              tx_byte_valid <= 1'b0;
              timer <= '0;
              state <= IN_WAIT;
            end else begin
              tx_byte <= mem[rd_spec + AW'(1)];
            end
          end
        end
      endcase
      if (stall_clr) begin
        stalled <= 1'b0;
        out_tog <= 1'b0;
        in_tog <= 1'b0;
      end else if (stall_set) begin
        stalled <= 1'b1;
      end
    end
  end
endmodule
